// File: rtl/nic_pkg.sv
// Shared constants and packet layout for the PE network interface.
// Statistics counters exist only when NIC_STATS_EN is defined.
package nic_pkg;
   localparam int DW    = 64;
   localparam int CNT_W = 16;

   localparam logic [1:0] ADDR_RXBUF = 2'd0;
   localparam logic [1:0] ADDR_RXST  = 2'd1;
   localparam logic [1:0] ADDR_TXBUF = 2'd2;
   localparam logic [1:0] ADDR_TXST  = 2'd3;

   localparam int VC_BIT  = 63;
   localparam int DIR_BIT = 62;

   // Field layout: VC [63], DIR [62], HOP [55:48], SRC [47:32], PAYLOAD [31:0].
   typedef struct packed {
      logic        vc;
      logic        dir;
      logic [5:0]  rsvd;
      logic [7:0]  hop;
      logic [15:0] src;
      logic [31:0] payload;
   } nic_pkt_t;

   function automatic logic pkt_vc(input logic [DW-1:0] pkt);
      return pkt[VC_BIT];
   endfunction

   function automatic logic pkt_dir(input logic [DW-1:0] pkt);
      return pkt[DIR_BIT];
   endfunction
endpackage

// File: rtl/nic_pe_if.sv
// Processor register bus plus router PE-port signals of one NIC.
// tx_count/rx_count are present only when NIC_STATS_EN is defined.
interface nic_pe_if;
   import nic_pkg::*;

   logic [1:0]    addr;
   logic [DW-1:0] d_in;
   logic [DW-1:0] d_out;
   logic          nicEn;
   logic          nicWrEn;
   logic          net_so;
   logic          net_ro;
   logic [DW-1:0] net_do;
   logic          net_si;
   logic          net_ri;
   logic [DW-1:0] net_di;
   logic          net_polarity;
`ifdef NIC_STATS_EN
   logic [CNT_W-1:0] tx_count;
   logic [CNT_W-1:0] rx_count;
`endif

   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      output d_out, net_so, net_do, net_ri
`ifdef NIC_STATS_EN
      , output tx_count, rx_count
`endif
   );

   modport master (
      output addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      input  d_out, net_so, net_do, net_ri
`ifdef NIC_STATS_EN
      , input tx_count, rx_count
`endif
   );
endinterface

// File: rtl/nic_chan_buf.sv
// Single-entry packet buffer with a full flag; load takes priority over clear.
module nic_chan_buf
   import nic_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_load,
   input  logic          i_clear,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_full
);
   logic [DW-1:0] r_data;
   logic          r_full;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (i_load) begin
         r_data <= i_data;
         r_full <= 1'b1;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_full = r_full;
endmodule

// File: rtl/nic_pe.sv
// PE-side network interface: TX/RX single-entry buffers, register decode and VC polarity gating.
// Optional packet counters are built when NIC_STATS_EN is defined.
module nic_pe
   import nic_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   nic_pe_if.slave  bus
);
   logic [DW-1:0] w_tx_buf;
   logic          w_tx_full;
   logic [DW-1:0] w_rx_buf;
   logic          w_rx_full;
   logic          w_wr;
   logic          w_rd;
   logic          w_tx_load;
   logic          w_send;
   logic          w_rx_accept;
   logic          w_rx_clear;
   logic [DW-1:0] w_rd_data;
   logic [DW-1:0] r_d_out;

   assign w_wr = bus.nicEn & bus.nicWrEn;
   assign w_rd = bus.nicEn & ~bus.nicWrEn;

   // A write while full (including the cycle the packet leaves) is refused.
   assign w_tx_load   = w_wr & (bus.addr == ADDR_TXBUF) & ~w_tx_full;
   // RST gates the send so it drops immediately when reset is asserted.
   assign w_send      = RST & w_tx_full & bus.net_ro & (pkt_vc(w_tx_buf) == bus.net_polarity);
   assign w_rx_accept = bus.net_si & ~w_rx_full;
   assign w_rx_clear  = w_rd & (bus.addr == ADDR_RXBUF);

   nic_chan_buf u_tx_buf (
      .CLK     (CLK),
      .RST     (RST),
      .i_load  (w_tx_load),
      .i_clear (w_send),
      .i_data  (bus.d_in),
      .o_data  (w_tx_buf),
      .o_full  (w_tx_full)
   );

   nic_chan_buf u_rx_buf (
      .CLK     (CLK),
      .RST     (RST),
      .i_load  (w_rx_accept),
      .i_clear (w_rx_clear),
      .i_data  (bus.net_di),
      .o_data  (w_rx_buf),
      .o_full  (w_rx_full)
   );

   always_comb begin
      w_rd_data = '0;
      case (bus.addr)
         ADDR_RXBUF: w_rd_data = w_rx_buf;
         ADDR_RXST:  w_rd_data = {{(DW-1){1'b0}}, w_rx_full};
         ADDR_TXBUF: w_rd_data = '0;
         ADDR_TXST:  w_rd_data = {{(DW-1){1'b0}}, w_tx_full};
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_d_out <= '0;
      end else if (w_rd) begin
         r_d_out <= w_rd_data;
      end
   end

   assign bus.d_out  = r_d_out;
   assign bus.net_so = w_send;
   assign bus.net_do = w_tx_buf;
   assign bus.net_ri = ~w_rx_full;

`ifdef NIC_STATS_EN
   logic [CNT_W-1:0] r_tx_count;
   logic [CNT_W-1:0] r_rx_count;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_tx_count <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_send)      r_tx_count <= r_tx_count + 1'b1;
         if (w_rx_accept) r_rx_count <= r_rx_count + 1'b1;
      end
   end

   assign bus.tx_count = r_tx_count;
   assign bus.rx_count = r_rx_count;
`endif
endmodule

// File: tb/tb_nic_pe.sv
// Scoreboard bench for nic_pe: stimulus queues expected reads/sends, a monitor pops and compares.
module tb_nic_pe;
   logic CLK;
   logic RST;
   nic_pe_if bus();

   nic_pe dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] q_rd[$];
   logic [63:0] q_tx[$];
   bit rd_flag = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: %h", name, act);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [63:0] d);
      bus.addr = a; bus.d_in = d; bus.nicEn = 1'b1; bus.nicWrEn = 1'b1;
      step;
      bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [63:0] exp);
      q_rd.push_back(exp);
      bus.addr = a; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
      step;
      bus.nicEn = 1'b0;
   endtask

   // Monitor: a read seen on one falling edge is checked on the next; sends checked as they occur.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge CLK);
         if (rd_flag) begin
            if (q_rd.size() == 0) begin
               n_tests++; n_fail++;
               $display("[TB] FAIL d_out: unexpected read data %h, expected none", bus.d_out);
            end else begin
               exp = q_rd.pop_front();
               check("d_out", bus.d_out, exp);
            end
         end
         rd_flag = RST && bus.nicEn && !bus.nicWrEn;
         if (bus.net_so) begin
            if (q_tx.size() == 0) begin
               n_tests++; n_fail++;
               $display("[TB] FAIL net_so: unexpected send of %h, expected none", bus.net_do);
            end else begin
               exp = q_tx.pop_front();
               check("net_do", bus.net_do, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0;
      bus.addr = 2'd0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
      bus.net_ro = 1'b0; bus.net_si = 1'b0; bus.net_di = '0; bus.net_polarity = 1'b0;

      // Reset
      step; step;
      #1; check("rst net_so", bus.net_so, 1'b0);
      check("rst net_ri", bus.net_ri, 1'b1);
      RST = 1'b1;
      #1; check("rst d_out", bus.d_out, 64'h0);
      rd(2'd1, 64'h0);
      rd(2'd3, 64'h0);
      rd(2'd0, 64'h0);

      // TX polarity gate
      bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
      wr(2'd2, 64'h8000_0000_0000_00AA);
      #1; check("gate hold net_so", bus.net_so, 1'b0);
      rd(2'd3, 64'h1);
      q_tx.push_back(64'h8000_0000_0000_00AA);
      bus.net_polarity = 1'b1;
      #1; check("gate open net_so", bus.net_so, 1'b1);
      step;
      #1; check("gate after net_so", bus.net_so, 1'b0);
      rd(2'd3, 64'h0);

      // TX backpressure, dropped write, refused write on send cycle
      bus.net_ro = 1'b0;
      wr(2'd2, 64'h8000_0000_0000_0011);
      step; #1; check("bp net_so", bus.net_so, 1'b0);
      step; #1; check("bp net_so", bus.net_so, 1'b0);
      wr(2'd2, 64'h8000_0000_0000_0022);
      step; #1; check("bp net_so", bus.net_so, 1'b0);
      step; #1; check("bp net_so", bus.net_so, 1'b0);
      check("bp net_do kept", bus.net_do, 64'h8000_0000_0000_0011);
      rd(2'd3, 64'h1);
      q_tx.push_back(64'h8000_0000_0000_0011);
      bus.net_ro = 1'b1;
      wr(2'd2, 64'h8000_0000_0000_0033);
      #1; check("refused wr net_so", bus.net_so, 1'b0);
      rd(2'd3, 64'h0);
      check("refused wr net_do", bus.net_do, 64'h8000_0000_0000_0011);

      // VC0 packet waits for polarity 0
      wr(2'd2, 64'h0000_0000_0000_0044);
      #1; check("vc0 wait net_so", bus.net_so, 1'b0);
      step;
      q_tx.push_back(64'h0000_0000_0000_0044);
      bus.net_polarity = 1'b0;
      step;
      #1; check("vc0 sent net_so", bus.net_so, 1'b0);
      rd(2'd3, 64'h0);

      // RX capture and read
      bus.net_di = 64'h1234; bus.net_si = 1'b1;
      #1; check("rx idle net_ri", bus.net_ri, 1'b1);
      step;
      bus.net_si = 1'b0;
      #1; check("rx full net_ri", bus.net_ri, 1'b0);
      rd(2'd1, 64'h1);
      rd(2'd0, 64'h1234);
      #1; check("rx read net_ri", bus.net_ri, 1'b1);
      rd(2'd1, 64'h0);

      // RX hold while full, pending packet captured after read
      bus.net_di = 64'hAAAA; bus.net_si = 1'b1;
      step;
      bus.net_di = 64'hBBBB;
      for (int i = 0; i < 4; i++) begin
         step; #1; check("rx hold net_ri", bus.net_ri, 1'b0);
      end
      rd(2'd0, 64'hAAAA);
      #1; check("rx reopen net_ri", bus.net_ri, 1'b1);
      step;
      bus.net_si = 1'b0;
      #1; check("rx pending net_ri", bus.net_ri, 1'b0);
      rd(2'd0, 64'hBBBB);
      rd(2'd1, 64'h0);
      rd(2'd0, 64'hBBBB);

      // Other accesses
      rd(2'd2, 64'h0);
      wr(2'd0, 64'hDEAD);
      wr(2'd1, 64'h1);
      wr(2'd3, 64'h1);
      rd(2'd3, 64'h0);
      rd(2'd1, 64'h0);
      rd(2'd0, 64'hBBBB);
      step; step; step;
      check("hold d_out", bus.d_out, 64'hBBBB);

      // Reset mid-operation
      bus.net_polarity = 1'b0;
      wr(2'd2, 64'h8000_0000_0000_00CC);
      bus.net_di = 64'hCC; bus.net_si = 1'b1;
      step;
      bus.net_si = 1'b0;
      RST = 1'b0; bus.net_polarity = 1'b1;
      #1; check("rst mid net_so", bus.net_so, 1'b0);
      step; step;
      RST = 1'b1;
      #1; check("rst mid d_out", bus.d_out, 64'h0);
      check("rst mid net_ri", bus.net_ri, 1'b1);
      check("rst mid net_so2", bus.net_so, 1'b0);
      rd(2'd3, 64'h0);
      rd(2'd1, 64'h0);
      rd(2'd0, 64'h0);

`ifdef NIC_STATS_EN
      check("stats tx0", bus.tx_count, 64'd0);
      check("stats rx0", bus.rx_count, 64'd0);
      bus.net_polarity = 1'b1; bus.net_ro = 1'b1;
      for (int i = 0; i < 3; i++) begin
         q_tx.push_back(64'h8000_0000_0000_0100 + 64'(i));
         wr(2'd2, 64'h8000_0000_0000_0100 + 64'(i));
         step;
      end
      for (int i = 0; i < 2; i++) begin
         bus.net_di = 64'h200 + 64'(i); bus.net_si = 1'b1;
         step;
         bus.net_si = 1'b0;
         rd(2'd0, 64'h200 + 64'(i));
      end
      #1; check("stats tx3", bus.tx_count, 64'd3);
      check("stats rx2", bus.rx_count, 64'd2);
      RST = 1'b0;
      step;
      RST = 1'b1;
      #1; check("stats tx clr", bus.tx_count, 64'd0);
      check("stats rx clr", bus.rx_count, 64'd0);
`endif

      step; step;
      check("rd queue drained", 64'(q_rd.size()), 64'd0);
      check("tx queue drained", 64'(q_tx.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
